// File: rtl/mem_dual_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, slot layouts,
// load_op encoding, stall polarity and the read-data hold FSM states.
package mem_dual_stage_pkg;

  // Per-slot and composite bus widths
  localparam int EX_SLOT_W = 75;
  localparam int WB_SLOT_W = 70;
  localparam int RF_SLOT_W = 38;
  localparam int EX_BUS_W  = 2 * EX_SLOT_W + 1;
  localparam int WB_BUS_W  = 2 * WB_SLOT_W + 1;
  localparam int RF_BUS_W  = 2 * RF_SLOT_W;

  // load_op bit indices (one-hot)
  localparam int LD_LB  = 0;
  localparam int LD_LBU = 1;
  localparam int LD_LH  = 2;
  localparam int LD_LHU = 3;
  localparam int LD_LW  = 4;

  localparam logic [4:0] OP_LB  = 5'b00001;
  localparam logic [4:0] OP_LBU = 5'b00010;
  localparam logic [4:0] OP_LH  = 5'b00100;
  localparam logic [4:0] OP_LHU = 5'b01000;
  localparam logic [4:0] OP_LW  = 5'b10000;

  // Stall bus polarity and the bits this stage looks at
  localparam logic STOP      = 1'b1;
  localparam logic NO_STOP   = 1'b0;
  localparam int   STALL_MEM = 4;
  localparam int   STALL_WB  = 5;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  load_op;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] ex_result;
  } ex_slot_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_slot_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_slot_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRESH = 2'd1,
    ST_HELD  = 2'd2
  } hold_state_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the addressed byte/halfword of a 32-bit
// little-endian read word and sign- or zero-extends it. Purely combinational.
module mem_load_align
  import mem_dual_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [4:0]  load_op,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection, then extension by load kind; a[0] is ignored for halfwords
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    result = 32'h0000_0000;
    case (addr)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (load_op)
      OP_LB:   result = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  result = {24'h00_0000, byte_s};
      OP_LH:   result = {{16{half_s[15]}}, half_s};
      OP_LHU:  result = {16'h0000, half_s};
      OP_LW:   result = rdata;
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_dual_stage.sv
// Dual-issue MEM stage: EX->MEM stage register, single-slot load alignment,
// MEM->WB and forwarding buses, plus a one-entry SRAM read-data hold buffer
// that keeps the synchronous read return valid while MEM is stalled.
module mem_dual_stage
  import mem_dual_stage_pkg::*;
#(
  parameter int SLOT_WD    = EX_SLOT_W,
  parameter int WB_SLOT_WD = WB_SLOT_W,
  parameter int RF_SLOT_WD = RF_SLOT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [5:0]              stall,
  input  logic [2*SLOT_WD:0]      ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [2*WB_SLOT_WD:0]   mem_to_wb_bus,
  output logic [2*RF_SLOT_WD-1:0] mem_to_rf_bus
);

  logic [2*SLOT_WD:0] stage_r;
  hold_state_t        state_r;
  hold_state_t        state_nxt_s;
  logic [31:0]        hold_r;
  logic [31:0]        hold_nxt_s;
  logic               hold_s;
  logic               bubble_s;
  logic               switch_s;
  ex_slot_t           slot0_s;
  ex_slot_t           slot1_s;
  logic [31:0]        rdata_eff_s;
  logic [31:0]        load_data_s;
  logic [31:0]        wdata0_s;
  wb_slot_t           wb0_s;
  wb_slot_t           wb1_s;
  rf_slot_t           rf0_s;
  rf_slot_t           rf1_s;

  // MEM and WB both stopped: the stage keeps its contents
  assign hold_s   = (stall[STALL_MEM] == STOP) && (stall[STALL_WB] == STOP);
  // MEM stopped while WB advances: push a bubble forward
  assign bubble_s = (stall[STALL_MEM] == STOP) && (stall[STALL_WB] == NO_STOP);

  // Stage register: reset, flush, bubble, load, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= '0;
    end else if (flush) begin
      stage_r <= '0;
    end else if (bubble_s) begin
      stage_r <= '0;
    end else if (stall[STALL_MEM] == NO_STOP) begin
      stage_r <= ex_to_mem_bus;
    end else begin
      stage_r <= stage_r;
    end
  end

  // Hold FSM next state: capture the live SRAM return on the first hold edge
  always_comb begin
    state_nxt_s = state_r;
    hold_nxt_s  = hold_r;
    if (rst || flush) begin
      state_nxt_s = ST_IDLE;
      hold_nxt_s  = 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!hold_s) begin
            state_nxt_s = ST_FRESH;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_FRESH: begin
          if (hold_s) begin
            state_nxt_s = ST_HELD;
            hold_nxt_s  = data_sram_rdata;
          end else begin
            state_nxt_s = ST_FRESH;
          end
        end
        ST_HELD: begin
          if (!hold_s) begin
            state_nxt_s = ST_FRESH;
          end else begin
            state_nxt_s = ST_HELD;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          hold_nxt_s  = 32'h0000_0000;
        end
      endcase
    end
  end

  // Hold FSM state and buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      hold_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      hold_r  <= hold_nxt_s;
    end
  end

  assign switch_s    = stage_r[2*SLOT_WD];
  assign slot1_s     = stage_r[2*SLOT_WD-1:SLOT_WD];
  assign slot0_s     = stage_r[SLOT_WD-1:0];
  assign rdata_eff_s = (state_r == ST_HELD) ? hold_r : data_sram_rdata;

  mem_load_align u_align (
    .rdata   (rdata_eff_s),
    .addr    (slot0_s.ex_result[1:0]),
    .load_op (slot0_s.load_op),
    .result  (load_data_s)
  );

  // Only slot0 can load; slot1 always writes back its ALU result
  assign wdata0_s = (slot0_s.load_op != 5'b00000) ? load_data_s : slot0_s.ex_result;

  assign wb0_s = '{pc: slot0_s.pc, we: slot0_s.we, waddr: slot0_s.waddr, wdata: wdata0_s};
  assign wb1_s = '{pc: slot1_s.pc, we: slot1_s.we, waddr: slot1_s.waddr, wdata: slot1_s.ex_result};
  assign rf0_s = '{we: slot0_s.we, waddr: slot0_s.waddr, wdata: wdata0_s};
  assign rf1_s = '{we: slot1_s.we, waddr: slot1_s.waddr, wdata: slot1_s.ex_result};

  assign mem_to_wb_bus = {switch_s, wb1_s, wb0_s};
  assign mem_to_rf_bus = {rf1_s, rf0_s};

endmodule

// File: doc/mem_dual_stage.md
# mem_dual_stage

Memory-access stage of the dual-issue pipeline. It latches the two-slot EX→MEM bus under the shared stall/flush controls. For the single memory-capable slot, it merges the data-SRAM read return and aligns and extends load data. It then drives the two-slot MEM→WB bus and the per-slot MEM forwarding bus back to ID. A one-entry read-data hold buffer keeps the synchronous SRAM return valid while MEM is stalled.

## Interface
Parameters:
- SLOT_WD, 75: per-slot EX→MEM width, packed {pc[74:43], load_op[42:38], we[37], waddr[36:32], ex_result[31:0]}.
- WB_SLOT_WD, 70: per-slot MEM→WB width, packed {pc[69:38], we[37], waddr[36:32], wdata[31:0]}.
- RF_SLOT_WD, 38: per-slot forwarding width, packed {we[37], waddr[36:32], wdata[31:0]}.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- flush, in, 1: squash the stage register.
- stall, in, 6: pipeline stall bus; bit 4 gates this stage, bit 5 gates WB.
- ex_to_mem_bus, in, 2*SLOT_WD+1: bit 150 = switch, [149:75] = slot1, [74:0] = slot0. Slot0 is first in program order.
- data_sram_rdata, in, 32: read data, valid exactly one cycle after the EX-stage request.
- mem_to_wb_bus, out, 2*WB_SLOT_WD+1: {switch, slot1, slot0}.
- mem_to_rf_bus, out, 2*RF_SLOT_WD: {slot1, slot0}.

## Operation
- Stage register (151 bits), evaluated on clk in priority order:
  - rst: load 0.
  - flush: load 0.
  - stall[4]=Stop and stall[5]=NoStop: load 0 (bubble).
  - stall[4]=NoStop: load ex_to_mem_bus.
  - Otherwise: hold.
- load_op one-hot: bit0 lb, bit1 lbu, bit2 lh, bit3 lhu, bit4 lw. Zero means not a load.
- Only slot0 may carry a load. A nonzero load_op in slot1 is ignored, and slot1 wdata = ex_result.
- Byte lane select is ex_result[1:0], little-endian:
  - lb/lbu: byte at rdata[8*a+7:8*a], sign- or zero-extended.
  - lh/lhu: halfword at rdata[16*a[1]+15:16*a[1]], sign- or zero-extended. a[0] is ignored; misalignment is handled upstream.
  - lw: the full word.
- Slot wdata is the aligned load data if the slot is a load, otherwise ex_result.
- Forwarding fields equal the WB fields minus pc. A load's forward value is the aligned load data.
- switch passes through unchanged to mem_to_wb_bus[140].
- Read-data hold FSM, states FRESH, HELD, IDLE:
  - IDLE→FRESH whenever the stage register loads a new value (any non-hold update, including a bubble).
  - FRESH→HELD on a hold cycle; at that edge, capture data_sram_rdata into hold_q.
  - HELD→FRESH on the next non-hold update.
  - rst or flush → IDLE, hold_q=0.
- Effective rdata is hold_q in HELD, otherwise data_sram_rdata.

## Timing
- Reset: the stage register is 0, so every output is 0 the cycle after rst; FSM is IDLE.
- Latency: one register stage. All outputs are combinational from the register, hold_q and data_sram_rdata.
- A load issued at EX in cycle N latches at edge N+1. Data appears on the outputs in cycle N+1 and stays stable for every stall cycle after that.
- flush beats stall. Simultaneous flush and stall[4]=NoStop gives 0.
- Bubble insertion drops to FSM FRESH with load_op=0, so rdata is unused.
- Reset mid-stall discards hold_q.

## Structure
- Shared defines header holds:
  - SLOT_WD, WB_SLOT_WD, RF_SLOT_WD and the composite bus widths.
  - The load_op bit indices.
  - Stop/NoStop.
- One sub-module, mem_load_align (rdata, addr[1:0], load_op → 32-bit result). It is purely combinational, so it can be unit-tested alone.
- The stage register and hold FSM live in the top module.

## Test plan
- Reset, then release with zero input: all outputs 0 and FSM IDLE.
- slot0 lb, ex_result=0x1003, rdata=0x80FF_1234, we=1, waddr=5: slot0 wdata=0xFFFF_FF80 and forward {1,5,0xFFFF_FF80}. Repeat as lbu: wdata=0x0000_0080.
- slot0 lh at addr 0x2: rdata=0x8001_7FFF gives wdata=0xFFFF_8001; lhu gives 0x0000_8001; lw gives 0x8001_7FFF.
- Load latched, then stall[4]=stall[5]=Stop for 3 cycles while data_sram_rdata changes to 0xDEAD_BEEF. Output stays at the original aligned value for all 3 cycles and the FSM is in HELD.
- stall[4]=Stop and stall[5]=NoStop: next cycle both slots are 0. Separately, flush together with stall[4]=NoStop on valid input: outputs 0.
- switch=1, slot1 ALU (ex_result=0x42, waddr=9) and slot1 load_op=lw: slot1 wdata=0x42 and mem_to_wb_bus[140]=1.
